// File: rtl/sdram_req_sched.sv
// sdram_req_sched: arbitrates the single SDRAM controller between the camera
// write channel and the VGA read channel. One full-row (512-word) burst is
// outstanding at a time. Each channel has its own row counter, and the banks
// ping-pong per frame: the camera writes bank_sel while VGA reads the other bank.
// Optional build macro: SCHED_RR_EN (round-robin on ties; default is fixed write priority).
module sdram_req_sched #(
    parameter int WR_THRESH = 512,
    parameter int RD_THRESH = 512,
    parameter int MAX_ROWS  = 938
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    input  logic        rd_enable,
    input  logic [10:0] wr_fifo_used,
    input  logic [10:0] rd_fifo_used,
    output logic        wr_sdram_req,
    input  logic        wr_sdram_ack,
    output logic [23:0] wr_sdram_add,
    output logic        rd_sdram_req,
    input  logic        rd_sdram_ack,
    output logic [23:0] rd_sdram_add,
    output logic        bank_sel,
    output logic        wr_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [12:0] MAX_ROW_C = 13'(MAX_ROWS);
    localparam logic [10:0] WR_TH_C   = 11'(WR_THRESH);
    localparam logic [10:0] RD_TH_C   = 11'(RD_THRESH);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [12:0] wr_row_r;
    logic [12:0] rd_row_r;
    logic        rd_bank_r;
    logic        wr_pend_r;
    logic        rd_pend_r;
    logic        wr_elig_s;
    logic        rd_elig_s;
    logic        grant_wr_s;
    logic        grant_rd_s;
    logic        wr_apply_s;
    logic        rd_apply_s;
    logic        wr_done_s;
    logic        rd_done_s;
`ifdef SCHED_RR_EN
    logic        last_wr_r;   // 1: the most recent grant went to write
`endif

    assign wr_elig_s  = (wr_fifo_used >= WR_TH_C) && (wr_row_r < MAX_ROW_C);
    assign rd_elig_s  = rd_enable && (rd_fifo_used <= RD_TH_C) && (rd_row_r < MAX_ROW_C);
    // A pending frame start never retargets an in-flight burst of its own channel
    assign wr_apply_s = wr_pend_r && (state_r != WR);
    assign rd_apply_s = rd_pend_r && (state_r != RD);
    assign wr_done_s  = (state_r == WR) && wr_sdram_ack;
    assign rd_done_s  = (state_r == RD) && rd_sdram_ack;

    // Arbitration: decide which channel, if any, IDLE grants this cycle
    always_comb begin
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (state_r == IDLE) begin
`ifdef SCHED_RR_EN
            if (wr_elig_s && rd_elig_s) begin
                grant_wr_s = ~last_wr_r;
                grant_rd_s = last_wr_r;
            end else begin
                grant_wr_s = wr_elig_s;
                grant_rd_s = rd_elig_s;
            end
`else
            grant_wr_s = wr_elig_s;
            grant_rd_s = rd_elig_s && !wr_elig_s;
`endif
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    // Next-state logic for the burst scheduler
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_wr_s) begin
                    state_nxt_s = WR;
                end else if (grant_rd_s) begin
                    state_nxt_s = RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR: begin
                if (wr_sdram_ack) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = WR;
                end
            end
            RD: begin
                if (rd_sdram_ack) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = RD;
                end
            end
            GAP:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Requests, addresses, row counters, bank ping-pong and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sdram_req <= 1'b0;
            wr_sdram_add <= 24'h000000;
            rd_sdram_req <= 1'b0;
            rd_sdram_add <= 24'h000000;
            wr_row_r     <= 13'd0;
            rd_row_r     <= 13'd0;
            bank_sel     <= 1'b0;
            rd_bank_r    <= 1'b0;
            wr_pend_r    <= 1'b0;
            rd_pend_r    <= 1'b0;
            wr_ovf       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Address is latched at grant time from the pre-apply row and bank
            if (grant_wr_s) begin
                wr_sdram_req <= 1'b1;
                wr_sdram_add <= {1'b0, bank_sel, wr_row_r, 9'd0};
            end else if (wr_done_s) begin
                wr_sdram_req <= 1'b0;
            end

            if (grant_rd_s) begin
                rd_sdram_req <= 1'b1;
                rd_sdram_add <= {1'b0, rd_bank_r, rd_row_r, 9'd0};
            end else if (rd_done_s) begin
                rd_sdram_req <= 1'b0;
            end

            if (wr_apply_s) begin
                wr_row_r <= 13'd0;
            end else if (wr_done_s && (wr_row_r < MAX_ROW_C)) begin
                wr_row_r <= wr_row_r + 13'd1;
            end

            if (rd_apply_s || (!rd_enable && (state_r != RD))) begin
                rd_row_r <= 13'd0;
            end else if (rd_done_s && (rd_row_r < MAX_ROW_C)) begin
                rd_row_r <= rd_row_r + 13'd1;
            end

            // Repeated start pulses while pending collapse into one toggle
            if (wr_apply_s) begin
                wr_pend_r <= 1'b0;
                bank_sel  <= ~bank_sel;
            end else if (wr_frame_start) begin
                wr_pend_r <= 1'b1;
            end

            // VGA reads the bank the camera most recently finished
            if (rd_apply_s) begin
                rd_pend_r <= 1'b0;
                rd_bank_r <= ~bank_sel;
            end else if (rd_frame_start) begin
                rd_pend_r <= 1'b1;
            end

            if (wr_apply_s) begin
                wr_ovf <= 1'b0;
            end else if ((wr_fifo_used >= WR_TH_C) && (wr_row_r == MAX_ROW_C)) begin
                wr_ovf <= 1'b1;
            end

            busy <= (state_nxt_s == WR) || (state_nxt_s == RD);
        end
    end

`ifdef SCHED_RR_EN
    // Remember which channel got the most recent grant; resets to read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_r <= 1'b0;
        end else if (grant_wr_s) begin
            last_wr_r <= 1'b1;
        end else if (grant_rd_s) begin
            last_wr_r <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_req_sched.sv
// Directed testbench for sdram_req_sched (MAX_ROWS reduced to 4 for short runs).
`timescale 1ns/1ps
module tb_sdram_req_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic        rd_enable;
    logic [10:0] wr_fifo_used;
    logic [10:0] rd_fifo_used;
    logic        wr_sdram_req;
    logic        wr_sdram_ack;
    logic [23:0] wr_sdram_add;
    logic        rd_sdram_req;
    logic        rd_sdram_ack;
    logic [23:0] rd_sdram_add;
    logic        bank_sel;
    logic        wr_ovf;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_req_sched #(.WR_THRESH(512), .RD_THRESH(512), .MAX_ROWS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .rd_enable(rd_enable),
        .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
        .wr_sdram_req(wr_sdram_req), .wr_sdram_ack(wr_sdram_ack), .wr_sdram_add(wr_sdram_add),
        .rd_sdram_req(rd_sdram_req), .rd_sdram_ack(rd_sdram_ack), .rd_sdram_add(rd_sdram_add),
        .bank_sel(bank_sel), .wr_ovf(wr_ovf), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_wr();
        wr_sdram_ack = 1'b1; tick(); wr_sdram_ack = 1'b0;
    endtask

    task automatic ack_rd();
        rd_sdram_ack = 1'b1; tick(); rd_sdram_ack = 1'b0;
    endtask

    task automatic pulse_wr_start();
        wr_frame_start = 1'b1; tick(); wr_frame_start = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_frame_start = 1'b1; tick(); rd_frame_start = 1'b0;
    endtask

    task automatic wait_wr(output logic got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!got) begin
                if (wr_sdram_req === 1'b1) got = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic wait_rd(output logic got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!got) begin
                if (rd_sdram_req === 1'b1) got = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic wait_any(output logic got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!got) begin
                if ((wr_sdram_req === 1'b1) || (rd_sdram_req === 1'b1)) got = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0; rd_enable = 1'b0;
        wr_fifo_used = 11'd0; rd_fifo_used = 11'd0;
        wr_sdram_ack = 1'b0; rd_sdram_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({wr_sdram_req, rd_sdram_req, bank_sel, wr_ovf, busy} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_flags: got %b exp 00000", {wr_sdram_req, rd_sdram_req, bank_sel, wr_ovf, busy});
        end
        tests++;
        if ({wr_sdram_add, rd_sdram_add} !== 48'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h/%h exp 0/0", wr_sdram_add, rd_sdram_add);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        ack_wr();                       // stray ack in IDLE must be ignored
        wr_fifo_used = 11'd511;
        tick(); tick(); tick();
        tests++;
        if (wr_sdram_req !== 1'b0) begin fails++; $display("FAIL wr_below_thresh: got %b exp 0", wr_sdram_req); end
        wr_fifo_used = 11'd600;
        tests++;
        if (wr_sdram_req !== 1'b0) begin fails++; $display("FAIL wr_req_not_comb: got %b exp 0", wr_sdram_req); end
        tick();
        tests++;
        if ({wr_sdram_req, busy} !== 2'b11) begin fails++; $display("FAIL wr_req_latency: got req,busy=%b exp 11", {wr_sdram_req, busy}); end
        tests++;
        if (wr_sdram_add !== 24'h000000) begin fails++; $display("FAIL wr_add_row0: got %h exp 000000", wr_sdram_add); end
        tick(); tick();
        tests++;
        if (wr_sdram_req !== 1'b1) begin fails++; $display("FAIL wr_req_hold: got %b exp 1", wr_sdram_req); end
        ack_wr();
        tests++;
        if ({wr_sdram_req, busy} !== 2'b00) begin fails++; $display("FAIL wr_req_drop: got req,busy=%b exp 00", {wr_sdram_req, busy}); end
        tick();
        tests++;
        if (wr_sdram_req !== 1'b0) begin fails++; $display("FAIL wr_gap: got %b exp 0", wr_sdram_req); end
        tick();
        tests++;
        if ({wr_sdram_req, wr_sdram_add} !== {1'b1, 24'h000200}) begin
            fails++; $display("FAIL wr_add_row1: got req=%b add=%h exp 1/000200", wr_sdram_req, wr_sdram_add);
        end
        ack_wr();
        wr_fifo_used = 11'd0;
        tick(); tick();
    endtask

    task automatic test_frame_bank();
        logic got;
        logic [23:0] exp_add;
        pulse_wr_start();
        tick();
        tests++;
        if (bank_sel !== 1'b1) begin fails++; $display("FAIL bank_toggle: got %b exp 1", bank_sel); end
        wr_fifo_used = 11'd600;
        for (int k = 0; k < 3; k++) begin
            exp_add = 24'h400000 + 24'(k * 512);
            wait_wr(got);
            tests++;
            if (got !== 1'b1) begin fails++; $display("FAIL bank1_req_timeout: got %b exp 1", got); end
            tests++;
            if (wr_sdram_add !== exp_add) begin fails++; $display("FAIL bank1_add: got %h exp %h", wr_sdram_add, exp_add); end
            ack_wr();
        end
        wr_fifo_used = 11'd0;
        tick(); tick();
    endtask

    task automatic test_ovf();
        logic got;
        logic seen;
        wr_fifo_used = 11'd600;
        wait_wr(got);
        tests++;
        if ({got, wr_sdram_add} !== {1'b1, 24'h400600}) begin
            fails++; $display("FAIL last_row: got %b/%h exp 1/400600", got, wr_sdram_add);
        end
        ack_wr();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_sdram_req === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL no_5th_req: got %b exp 0", seen); end
        tests++;
        if (wr_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", wr_ovf); end
        pulse_wr_start();
        tick();
        tests++;
        if ({wr_ovf, bank_sel} !== 2'b00) begin fails++; $display("FAIL ovf_clear: got ovf,bank=%b exp 00", {wr_ovf, bank_sel}); end
        wait_wr(got);
        tests++;
        if ({got, wr_sdram_add} !== {1'b1, 24'h000000}) begin
            fails++; $display("FAIL resume_row0: got %b/%h exp 1/000000", got, wr_sdram_add);
        end
        ack_wr();
        wr_fifo_used = 11'd0;
        tick(); tick();
    endtask

    task automatic test_tie();
        logic got;
        logic exp_wr;
        logic [23:0] exp_add;
        logic [23:0] act_add;
        int wcnt;
        int rcnt;
        apply_reset();
        rst_n = 1'b1;
        tick();
        wcnt = 0;
        rcnt = 0;
        wr_fifo_used = 11'd600;
        rd_fifo_used = 11'd100;
        rd_enable = 1'b1;
        for (int g = 0; g < 3; g++) begin
`ifdef SCHED_RR_EN
            exp_wr = (g != 1);
`else
            exp_wr = 1'b1;
`endif
            wait_any(got);
            tests++;
            if (got !== 1'b1) begin fails++; $display("FAIL tie_timeout: grant %0d got %b exp 1", g, got); end
            tests++;
            if ({wr_sdram_req, rd_sdram_req} !== {exp_wr, ~exp_wr}) begin
                fails++; $display("FAIL tie_grant%0d: got wr,rd=%b%b exp %b%b", g, wr_sdram_req, rd_sdram_req, exp_wr, ~exp_wr);
            end
            if (exp_wr) begin
                exp_add = 24'(wcnt * 512); act_add = wr_sdram_add; wcnt++;
            end else begin
                exp_add = 24'(rcnt * 512); act_add = rd_sdram_add; rcnt++;
            end
            tests++;
            if (act_add !== exp_add) begin fails++; $display("FAIL tie_add%0d: got %h exp %h", g, act_add, exp_add); end
            if (rd_sdram_req === 1'b1) ack_rd();
            else ack_wr();
        end
        wr_fifo_used = 11'd0;
        rd_enable = 1'b0;
        tick(); tick();
        pulse_wr_start();
        tick();
    endtask

    task automatic test_frame_mid_wr();
        logic got;
        wr_fifo_used = 11'd600;
        wait_wr(got);
        tests++;
        if ({got, wr_sdram_add} !== {1'b1, 24'h400000}) begin
            fails++; $display("FAIL mid_first: got %b/%h exp 1/400000", got, wr_sdram_add);
        end
        pulse_wr_start();
        tick();
        tests++;
        if ({wr_sdram_req, bank_sel, wr_sdram_add} !== {2'b11, 24'h400000}) begin
            fails++; $display("FAIL mid_hold: got req=%b bank=%b add=%h exp 1/1/400000", wr_sdram_req, bank_sel, wr_sdram_add);
        end
        ack_wr();
        tests++;
        if ({wr_sdram_req, bank_sel} !== 2'b01) begin fails++; $display("FAIL mid_exit: got req,bank=%b exp 01", {wr_sdram_req, bank_sel}); end
        tick();
        tests++;
        if (bank_sel !== 1'b0) begin fails++; $display("FAIL mid_toggle: got %b exp 0", bank_sel); end
        wait_wr(got);
        tests++;
        if ({got, wr_sdram_add} !== {1'b1, 24'h000000}) begin
            fails++; $display("FAIL mid_next_row0: got %b/%h exp 1/000000", got, wr_sdram_add);
        end
        ack_wr();
        wr_fifo_used = 11'd0;
        tick(); tick();
    endtask

    task automatic test_rd_drop();
        logic got;
        rd_fifo_used = 11'd513;
        pulse_rd_start();
        tick();
        rd_enable = 1'b1;
        tick(); tick(); tick();
        tests++;
        if (rd_sdram_req !== 1'b0) begin fails++; $display("FAIL rd_above_thresh: got %b exp 0", rd_sdram_req); end
        rd_fifo_used = 11'd512;
        wait_rd(got);
        tests++;
        if ({got, busy, rd_sdram_add} !== {2'b11, 24'h400000}) begin
            fails++; $display("FAIL rd_first: got %b busy=%b add=%h exp 1/1/400000", got, busy, rd_sdram_add);
        end
        ack_rd();
        wait_rd(got);
        tests++;
        if ({got, rd_sdram_add} !== {1'b1, 24'h400200}) begin
            fails++; $display("FAIL rd_second: got %b/%h exp 1/400200", got, rd_sdram_add);
        end
        rd_enable = 1'b0;
        tick(); tick();
        tests++;
        if ({rd_sdram_req, rd_sdram_add} !== {1'b1, 24'h400200}) begin
            fails++; $display("FAIL rd_hold: got %b/%h exp 1/400200", rd_sdram_req, rd_sdram_add);
        end
        ack_rd();
        tests++;
        if (rd_sdram_req !== 1'b0) begin fails++; $display("FAIL rd_drop: got %b exp 0", rd_sdram_req); end
        tick(); tick(); tick();
        tests++;
        if (rd_sdram_req !== 1'b0) begin fails++; $display("FAIL rd_disabled: got %b exp 0", rd_sdram_req); end
        rd_enable = 1'b1;
        wait_rd(got);
        tests++;
        if ({got, rd_sdram_add} !== {1'b1, 24'h400000}) begin
            fails++; $display("FAIL rd_row_cleared: got %b/%h exp 1/400000", got, rd_sdram_add);
        end
        ack_rd();
        rd_enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_frame_bank();
        test_ovf();
        test_tie();
        test_frame_mid_wr();
        test_rd_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
